// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline hazard controller: opcodes, FSM encoding
// and pipeline-register stage indices for the pr_write / pr_flush vectors.
package pipeline_pkg;

  localparam logic [3:0] OPC_LM = 4'b0110;  // load multiple
  localparam logic [3:0] OPC_SM = 4'b0111;  // store multiple
  localparam logic [3:0] OPC_LW = 4'b0100;  // load word

  typedef enum logic {
    StRun = 1'b0,
    StSeq = 1'b1
  } hz_state_e;

  // Bit positions in pr_write / pr_flush (bit 0 = pipeline register 1).
  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned STG_PR1    = 0;
  localparam int unsigned STG_PR2    = 1;
  localparam int unsigned STG_PR3    = 2;
  localparam int unsigned STG_PR4    = 3;
  localparam int unsigned STG_PR5    = 4;

endpackage

// File: rtl/lsb_encoder8.sv
// Lowest-set-bit encoder for the 8-bit LM/SM register list: returns the index
// of the lowest set bit and a one-hot mask selecting that bit (zero if empty).
module lsb_encoder8 (
  input  logic [7:0] i_mask,
  output logic [2:0] o_idx,
  output logic [7:0] o_clr
);

  // Isolate the lowest set bit (two's-complement trick).
  assign o_clr = i_mask & (~i_mask + 8'd1);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    o_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_mask[i]) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and LM/SM
// micro-sequencing of the decode-stage instruction.
// Build option: define LOAD_USE_STALL_EN to enable the load-use stall; when
// undefined, ex_opcode/ex_rd are ignored and software schedules loads.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [3:0] OP_LM = OPC_LM,
  parameter logic [3:0] OP_SM = OPC_SM,
  parameter logic [3:0] OP_LW = OPC_LW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] id_opcode,
  input  logic [2:0] id_ra,
  input  logic [2:0] id_rb,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic [7:0] id_imm8,
  input  logic [3:0] ex_opcode,
  input  logic [2:0] ex_rd,
  input  logic       redirect,
  output logic       pc_write,
  output logic [4:0] pr_write,
  output logic [4:0] pr_flush,
  output logic       lmsm_valid,
  output logic [2:0] lmsm_reg,
  output logic [2:0] lmsm_offset
);

  hz_state_e  r_state, w_state_next;
  logic [7:0] r_mask, w_mask_next;
  logic [2:0] r_off, w_off_next;

  logic [2:0] w_lsb_idx;
  logic [7:0] w_lsb_clr;
  logic       w_load_use;
  logic       w_is_lmsm;
  logic       w_multi;

  lsb_encoder8 u_lsb (
    .i_mask (r_mask),
    .o_idx  (w_lsb_idx),
    .o_clr  (w_lsb_clr)
  );

`ifdef LOAD_USE_STALL_EN
  assign w_load_use = (ex_opcode == OP_LW) &&
                      ((id_uses_ra && (id_ra == ex_rd)) || (id_uses_rb && (id_rb == ex_rd)));
`else
  logic w_unused_ex;
  assign w_unused_ex = ^{ex_opcode, ex_rd, id_ra, id_rb, id_uses_ra, id_uses_rb, OP_LW};
  assign w_load_use  = 1'b0;
`endif

  assign w_is_lmsm = (id_opcode == OP_LM) || (id_opcode == OP_SM);
  // More than one bit left means this is not the final transfer.
  assign w_multi   = |(r_mask & (r_mask - 8'd1));

  // Next-state and output decode; redirect outranks load-use, which outranks LM/SM.
  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_off_next   = r_off;
    pc_write     = 1'b1;
    pr_write     = 5'b11111;
    pr_flush     = 5'b00000;
    lmsm_valid   = 1'b0;
    lmsm_reg     = 3'd0;
    lmsm_offset  = 3'd0;

    if (redirect) begin
      pr_flush[STG_PR1] = 1'b1;
      pr_flush[STG_PR2] = 1'b1;
      w_state_next      = StRun;
      w_mask_next       = 8'h00;
      w_off_next        = 3'd0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_load_use) begin
            pc_write          = 1'b0;
            pr_write[STG_PR1] = 1'b0;
            pr_flush[STG_PR2] = 1'b1;
          end else if (w_is_lmsm && (id_imm8 != 8'h00)) begin
            pc_write          = 1'b0;
            pr_write[STG_PR1] = 1'b0;
            w_mask_next       = id_imm8;
            w_off_next        = 3'd0;
            w_state_next      = StSeq;
          end
        end
        StSeq: begin
          lmsm_valid  = 1'b1;
          lmsm_reg    = w_lsb_idx;
          lmsm_offset = r_off;
          w_mask_next = r_mask & ~w_lsb_clr;
          w_off_next  = r_off + 3'd1;
          if (w_multi) begin
            pc_write          = 1'b0;
            pr_write[STG_PR1] = 1'b0;
          end else begin
            w_state_next = StRun;
          end
        end
        default: w_state_next = StRun;
      endcase
    end

    // Reset forces a full bubble and a frozen PC regardless of state.
    if (!reset) begin
      pc_write    = 1'b0;
      pr_write    = 5'b11111;
      pr_flush    = 5'b11111;
      lmsm_valid  = 1'b0;
      lmsm_reg    = 3'd0;
      lmsm_offset = 3'd0;
    end
  end

  // State, list mask and transfer offset registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StRun;
      r_mask  <= 8'h00;
      r_off   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      r_off   <= w_off_next;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// outputs into a queue; a monitor pops and compares on each falling edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_opcode;
  logic [2:0] id_ra, id_rb;
  logic       id_uses_ra, id_uses_rb;
  logic [7:0] id_imm8;
  logic [3:0] ex_opcode;
  logic [2:0] ex_rd;
  logic       redirect;
  logic       pc_write;
  logic [4:0] pr_write, pr_flush;
  logic       lmsm_valid;
  logic [2:0] lmsm_reg, lmsm_offset;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_opcode   (id_opcode),
    .id_ra       (id_ra),
    .id_rb       (id_rb),
    .id_uses_ra  (id_uses_ra),
    .id_uses_rb  (id_uses_rb),
    .id_imm8     (id_imm8),
    .ex_opcode   (ex_opcode),
    .ex_rd       (ex_rd),
    .redirect    (redirect),
    .pc_write    (pc_write),
    .pr_write    (pr_write),
    .pr_flush    (pr_flush),
    .lmsm_valid  (lmsm_valid),
    .lmsm_reg    (lmsm_reg),
    .lmsm_offset (lmsm_offset)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] id_op;
    logic [2:0] ra, rb;
    logic       ua, ub;
    logic [7:0] imm;
    logic [3:0] ex_op;
    logic [2:0] ex_rd;
    logic       redir;
  } stim_t;

  typedef struct {
    string      name;
    logic       pcw;
    logic [4:0] prw, prf;
    logic       lv;
    logic [2:0] lr, lo;
    bit         chk_l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic stim_t s_idle();
    stim_t s;
    s.rst_n = 1'b1; s.id_op = 4'b0000; s.ra = 3'd0; s.rb = 3'd0; s.ua = 1'b0; s.ub = 1'b0;
    s.imm = 8'h00; s.ex_op = 4'b0000; s.ex_rd = 3'd0; s.redir = 1'b0;
    return s;
  endfunction

  function automatic exp_t e_mk(logic pcw, logic [4:0] prw, logic [4:0] prf, logic lv,
                                logic [2:0] lr, logic [2:0] lo, bit chk_l);
    exp_t e;
    e.name = ""; e.pcw = pcw; e.prw = prw; e.prf = prf; e.lv = lv; e.lr = lr; e.lo = lo;
    e.chk_l = chk_l;
    return e;
  endfunction

  function automatic exp_t e_run();   return e_mk(1, 5'b11111, 5'b00000, 0, 0, 0, 1); endfunction
  function automatic exp_t e_rst();   return e_mk(0, 5'b11111, 5'b11111, 0, 0, 0, 1); endfunction
  function automatic exp_t e_entry(); return e_mk(0, 5'b11110, 5'b00000, 0, 0, 0, 1); endfunction
  function automatic exp_t e_redir(bit chk_l);
    return e_mk(1, 5'b11111, 5'b00011, 0, 0, 0, chk_l);
  endfunction
  function automatic exp_t e_seq(logic [2:0] r, logic [2:0] o, bit last);
    return e_mk(last, last ? 5'b11111 : 5'b11110, 5'b00000, 1, r, o, 1);
  endfunction
  // Load-use outcome depends on whether the stall feature is built in.
  function automatic exp_t e_hz();
`ifdef LOAD_USE_STALL_EN
    return e_mk(0, 5'b11110, 5'b00010, 0, 0, 0, 1);
`else
    return e_run();
`endif
  endfunction

  task automatic apply(input string nm, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    reset = s.rst_n; id_opcode = s.id_op; id_ra = s.ra; id_rb = s.rb;
    id_uses_ra = s.ua; id_uses_rb = s.ub; id_imm8 = s.imm;
    ex_opcode = s.ex_op; ex_rd = s.ex_rd; redirect = s.redir;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        bit   ok;
        e  = exp_q.pop_front();
        ok = (pc_write === e.pcw) && (pr_write === e.prw) && (pr_flush === e.prf);
        if (e.chk_l)
          ok = ok && (lmsm_valid === e.lv) && (lmsm_reg === e.lr) && (lmsm_offset === e.lo);
        n_checks++;
        if (ok) n_pass++;
        else
          $display("FAIL %s: got pcw=%b prw=%b prf=%b lv=%b lr=%0d lo=%0d; want pcw=%b prw=%b prf=%b lv=%b lr=%0d lo=%0d",
                   e.name, pc_write, pr_write, pr_flush, lmsm_valid, lmsm_reg, lmsm_offset,
                   e.pcw, e.prw, e.prf, e.lv, e.lr, e.lo);
      end
    end
  end

  initial begin
    stim_t s;
    stim_t hz;
    reset = 1'b0; id_opcode = 4'b0000; id_ra = 3'd0; id_rb = 3'd0; id_uses_ra = 1'b0;
    id_uses_rb = 1'b0; id_imm8 = 8'h00; ex_opcode = 4'b0000; ex_rd = 3'd0; redirect = 1'b0;

    // Reset held two cycles, then release.
    s = s_idle(); s.rst_n = 1'b0;
    apply("reset_c1", s, e_rst());
    apply("reset_c2", s, e_rst());
    apply("release_run", s_idle(), e_run());

    // Load-use on ra, then a normal cycle.
    hz = s_idle(); hz.ex_op = 4'b0100; hz.ex_rd = 3'd3; hz.ra = 3'd3; hz.ua = 1'b1;
    apply("load_use_ra", hz, e_hz());
    apply("after_load_use", s_idle(), e_run());
    // Load-use on rb.
    s = s_idle(); s.ex_op = 4'b0100; s.ex_rd = 3'd5; s.rb = 3'd5; s.ub = 1'b1; s.ra = 3'd5;
    apply("load_use_rb", s, e_hz());
    // Matching register but not read: never a hazard.
    s = s_idle(); s.ex_op = 4'b0100; s.ex_rd = 3'd2; s.ra = 3'd2; s.ua = 1'b0;
    apply("no_use_no_stall", s, e_run());
    // Matching register read, but ex is not a load.
    s = s_idle(); s.ex_op = 4'b0110; s.ex_rd = 3'd2; s.ra = 3'd2; s.ua = 1'b1;
    apply("not_load_no_stall", s, e_run());

    // LM with list 1001_0010: regs 1,4,7 at offsets 0,1,2; load-use ignored in SEQ.
    s = s_idle(); s.id_op = 4'b0110; s.imm = 8'b1001_0010;
    apply("lm_entry", s, e_entry());
    apply("lm_seq1", s, e_seq(3'd1, 3'd0, 0));
    s.ex_op = 4'b0100; s.ex_rd = 3'd1; s.ra = 3'd1; s.ua = 1'b1;
    apply("lm_seq2_hz_suppressed", s, e_seq(3'd4, 3'd1, 0));
    s.ex_op = 4'b0000; s.ua = 1'b0;
    apply("lm_seq3_last", s, e_seq(3'd7, 3'd2, 1));
    apply("lm_back_to_run", s_idle(), e_run());

    // Redirect in the second SEQ cycle of an 8-register LM.
    s = s_idle(); s.id_op = 4'b0110; s.imm = 8'hFF;
    apply("ff_entry", s, e_entry());
    apply("ff_seq1", s, e_seq(3'd0, 3'd0, 0));
    s.redir = 1'b1;
    apply("ff_redirect", s, e_redir(0));
    apply("ff_after_redirect_run", s_idle(), e_run());

    // Redirect together with a load-use hazard: redirect wins, no stall.
    s = hz; s.redir = 1'b1;
    apply("redirect_plus_hz", s, e_redir(1));
    // Redirect with an LM in decode: no sequence entry.
    s = s_idle(); s.id_op = 4'b0110; s.imm = 8'hFF; s.redir = 1'b1;
    apply("redirect_blocks_lm", s, e_redir(1));
    apply("no_seq_after_redirect", s_idle(), e_run());

    // SM with empty list passes through as a normal instruction.
    s = s_idle(); s.id_op = 4'b0111; s.imm = 8'h00;
    apply("sm_zero", s, e_run());
    apply("sm_zero_next", s_idle(), e_run());

    // SM with a single register: one SEQ cycle, offset 0.
    s = s_idle(); s.id_op = 4'b0111; s.imm = 8'h80;
    apply("sm_single_entry", s, e_entry());
    apply("sm_single_seq", s, e_seq(3'd7, 3'd0, 1));
    apply("sm_single_run", s_idle(), e_run());

    // Reset mid-sequence abandons it.
    s = s_idle(); s.id_op = 4'b0110; s.imm = 8'h0C;
    apply("rst_seq_entry", s, e_entry());
    apply("rst_seq_seq1", s, e_seq(3'd2, 3'd0, 0));
    s.rst_n = 1'b0;
    apply("rst_in_seq", s, e_rst());
    apply("rst_release_run", s_idle(), e_run());

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: OP_LM, 4'b0110, load-multiple opcode; OP_SM, 4'b0111, store-multiple opcode; OP_LW, 4'b0100, load-word opcode.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clk).
REQ-004 id_opcode  input  4  opcode of the instruction held in pipeline register 1 (decode stage).
REQ-005 id_ra, id_rb  input  3 each  source register fields of the decode-stage instruction.
REQ-006 id_uses_ra, id_uses_rb  input  1 each  decode-stage instruction reads ra / rb.
REQ-007 id_imm8  input  8  LM/SM register list of the decode-stage instruction.
REQ-008 ex_opcode  input  4  opcode in the execute stage; ex_rd  input  3  its destination register.
REQ-009 redirect  input  1  branch or jump resolved taken in the execute stage.
REQ-010 pc_write  output  1  PC load enable.
REQ-011 pr_write  output  5  per-stage pipeline-register write enables; bit 0 = register 1 ... bit 4 = register 5.
REQ-012 pr_flush  output  5  per-stage bubble insert; the register loads a NOP instead of its input.
REQ-013 lmsm_valid  output  1; lmsm_reg  output  3; lmsm_offset  output  3  current LM/SM transfer: register index and word offset from the base.

Function
REQ-014 The FSM SHALL have states RUN and SEQ.
REQ-015 In RUN with no event, outputs SHALL be pc_write=1, pr_write=5'b11111, pr_flush=5'b00000, lmsm_valid=0.
REQ-016 Load-use hazard = (ex_opcode==OP_LW) and ((id_uses_ra and id_ra==ex_rd) or (id_uses_rb and id_rb==ex_rd)).
REQ-017 On a load-use hazard, for that cycle only: pc_write=0, pr_write[0]=0, pr_flush[1]=1; other bits are as in RUN.
REQ-018 On redirect: pc_write=1, pr_flush[1:0]=2'b11, pr_write=5'b11111; the FSM SHALL go to RUN, clearing the mask and the offset.
REQ-019 Priority: redirect > load-use > LM/SM entry or step.
REQ-020 In RUN with id_opcode in {OP_LM, OP_SM} and id_imm8!=0, the 8-bit mask SHALL load id_imm8 and the offset SHALL load 0, with entry to SEQ on the next edge; in that cycle pc_write=0 and pr_write[0]=0.
REQ-021 LM/SM with id_imm8==0 SHALL pass through as in RUN, with lmsm_valid never asserted.
REQ-022 In SEQ, lmsm_valid=1 and lmsm_reg = index of the lowest set mask bit.
REQ-023 In SEQ, lmsm_offset = offset; each cycle the lowest set bit SHALL clear and the offset SHALL increment by 1 (mod 8).
REQ-024 In SEQ with more than one mask bit set: pc_write=0, pr_write[0]=0, pr_flush[1]=0.
REQ-025 In SEQ with exactly one mask bit set: pc_write=1, pr_write[0]=1, with return to RUN on the next edge.
REQ-026 An n-bit list SHALL take exactly n SEQ cycles; the decode stage SHALL hold for n cycles in total.
REQ-027 Load-use detection SHALL be suppressed in SEQ.

Reset
REQ-028 While reset==0: state=RUN, mask=8'h00, offset=3'd0, pc_write=0, pr_write=5'b11111, pr_flush=5'b11111, lmsm_valid=0, lmsm_reg=0, lmsm_offset=0.
REQ-029 Reset asserted in SEQ SHALL abandon the sequence; the first cycle after release SHALL behave as RUN.

Configuration
REQ-030 Macro LOAD_USE_STALL_EN: when defined, REQ-016/REQ-017 SHALL apply.
REQ-031 When LOAD_USE_STALL_EN is undefined, no load-use stall SHALL occur: software schedules loads, and the ex_opcode/ex_rd inputs SHALL be ignored.

Structure
REQ-032 Package pipeline_pkg SHALL hold the opcode constants, the FSM state encoding, and the stage-index constants for pr_write/pr_flush.
REQ-033 Sub-module lsb_encoder8 SHALL provide the lowest-set-bit index and the one-hot clear mask for the 8-bit list.

Verification
REQ-034 Reset: hold reset=0 for 2 cycles -> pr_flush=5'b11111, lmsm_valid=0; release -> RUN outputs per REQ-015.
REQ-035 Load-use: ex_opcode=4'b0100, ex_rd=3, id_ra=3, id_uses_ra=1 -> one cycle with pc_write=0, pr_write=5'b11110, pr_flush=5'b00010; the next cycle is normal.
REQ-036 LM: id_opcode=4'b0110, id_imm8=8'b10010010 -> three SEQ cycles with lmsm_reg=1,4,7 and lmsm_offset=0,1,2; pc_write=1 only in the third.
REQ-037 Redirect mid-SEQ: imm8=8'hFF, redirect=1 in the 2nd SEQ cycle -> pr_flush=5'b00011; RUN next cycle; lmsm_valid=0.
REQ-038 Simultaneous events: redirect=1 plus a load-use hazard -> pc_write=1, pr_flush=5'b00011, no stall.
REQ-039 Zero list: SM with imm8=8'h00 -> no SEQ entry, lmsm_valid=0.
REQ-040 Configuration: with LOAD_USE_STALL_EN undefined, rerun REQ-035 -> no stall.
